clock_divider_prog: RTL

Runtime-programmable, parametrised clock/tick divider. Generalises the fixed-divisor 7 Hz divider.
- Divisor is loaded at run time and applied glitch-free at a period boundary.
- Adds a period-wrap tick, enable/pause, invalid-divisor rejection and a load acknowledge.
- Sits between the board oscillator and slow logic (display scan, debouncers, blinkers). Outputs are clock-enable-grade signals in the clock_in domain.

---
 rtl/clock_divider_prog_if.sv | 35 +++
 rtl/clock_divider_prog.sv | 94 +++++++++
 2 files changed

// File: rtl/clock_divider_prog_if.sv
// Control/status bundle for clock_divider_prog.
// With CLKDIV_QUAD_EN defined the bundle also carries the quadrature output clock_q.
interface clock_divider_prog_if #(
    parameter int WIDTH = 28
);
    logic             enable;
    logic             div_load;
    logic [WIDTH-1:0] div_value;
    logic             clock_out;
    logic             tick;
    logic             div_ack;
    logic             div_err;
    logic             busy;
`ifdef CLKDIV_QUAD_EN
    logic             clock_q;

    modport master (
        output enable, div_load, div_value,
        input  clock_out, tick, div_ack, div_err, busy, clock_q
    );
    modport slave (
        input  enable, div_load, div_value,
        output clock_out, tick, div_ack, div_err, busy, clock_q
    );
`else
    modport master (
        output enable, div_load, div_value,
        input  clock_out, tick, div_ack, div_err, busy
    );
    modport slave (
        input  enable, div_load, div_value,
        output clock_out, tick, div_ack, div_err, busy
    );
`endif
endinterface

// File: rtl/clock_divider_prog.sv
// Runtime-programmable clock/tick divider; new divisors take effect only at a period boundary.
// Optional quadrature output clock_q is built when CLKDIV_QUAD_EN is defined.
//
// state   | meaning
// ST_IDLE | no divisor waiting to be applied
// ST_PEND | a validated divisor sits in div_pend, applied at next wrap (or next edge when paused)
module clock_divider_prog #(
    parameter int          WIDTH       = 28,
    parameter int unsigned DEFAULT_DIV = 14285714
) (
    input  logic                 clock_in,
    input  logic                 reset,
    clock_divider_prog_if.slave  bus
);
    typedef enum logic {ST_IDLE, ST_PEND} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] counter, div_active, div_pend;
    logic [WIDTH-1:0] half, last;
    logic             wrap, load_ok, load_bad, apply, busy;
    logic             clk_r, tick_r, ack_r, err_r;

    assign half     = div_active >> 1;
    assign last     = div_active - WIDTH'(1);
    assign wrap     = bus.enable && (counter == last);
    assign load_ok  = bus.div_load && (bus.div_value >= WIDTH'(2));
    assign load_bad = bus.div_load && (bus.div_value <  WIDTH'(2));

    always_ff @(posedge clock_in) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // A load arriving on the apply edge becomes the next pending value.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (load_ok)            state_nxt = ST_PEND;
            ST_PEND: if (apply && !load_ok)  state_nxt = ST_IDLE;
            default:                         state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy  = (state == ST_PEND);
        apply = busy && (wrap || !bus.enable);
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            counter    <= '0;
            div_active <= WIDTH'(DEFAULT_DIV);
            div_pend   <= WIDTH'(DEFAULT_DIV);
            clk_r      <= 1'b0;
            tick_r     <= 1'b0;
            ack_r      <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            tick_r <= wrap;
            ack_r  <= apply;
            err_r  <= load_bad;
            if (load_ok) div_pend   <= bus.div_value;
            if (apply)   div_active <= div_pend;
            if (bus.enable)  clk_r <= (counter < half);
            else if (apply)  clk_r <= 1'b0;
            if (apply || wrap)   counter <= '0;
            else if (bus.enable) counter <= counter + WIDTH'(1);
        end
    end

    assign bus.clock_out = clk_r;
    assign bus.tick      = tick_r;
    assign bus.div_ack   = ack_r;
    assign bus.div_err   = err_r;
    assign bus.busy      = busy;

`ifdef CLKDIV_QUAD_EN
    logic [WIDTH-1:0] q_start;
    logic [WIDTH:0]   q_end;
    logic             q_r;

    // Widened end point so q + half can never wrap.
    assign q_start = div_active >> 2;
    assign q_end   = {1'b0, q_start} + {1'b0, half};

    always_ff @(posedge clock_in) begin
        if (reset)           q_r <= 1'b0;
        else if (bus.enable) q_r <= (counter >= q_start) && ({1'b0, counter} < q_end);
        else if (apply)      q_r <= 1'b0;
    end

    assign bus.clock_q = q_r;
`endif
endmodule
